// File: rtl/fifo_pkg.sv
// ============================================================================
// fifo_pkg : shared FSM state type and ratio/count-width helpers for the
//            bus-width converters.  Revision 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic int ratio_f(input int size_wide, input int size_narrow);
    return size_wide / size_narrow;
  endfunction

  // Keeps the counter at least one bit wide even for degenerate ratios.
  function automatic int cnt_width_f(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_width_decrease.sv
// ============================================================================
// bus_width_decrease : splits SIZE_IN-bit words into SIZE_IN/SIZE_OUT beats,
//   LSB slice first, valid/ready on both sides.  Optional port last_out is
//   enabled by macro BUS_WIDTH_DECREASE_LAST_EN.  Revision 1.0
// ============================================================================
`default_nettype none

module bus_width_decrease
  import fifo_pkg::*;
#(
  parameter int SIZE_IN  = 32,
  parameter int SIZE_OUT = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
  output logic                ready_in,
  input  logic [SIZE_IN-1:0]  data_in,
  output logic                valid_out,
  input  logic                ready_out,
`ifdef BUS_WIDTH_DECREASE_LAST_EN
  output logic                last_out,
`endif
  output logic [SIZE_OUT-1:0] data_out
);

  localparam int c_ratio = ratio_f(SIZE_IN, SIZE_OUT);
  localparam int c_cnt_w = cnt_width_f(c_ratio);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_ratio - 1);

  generate
    if ((SIZE_IN % SIZE_OUT) != 0 || c_ratio < 2) begin : g_bad_param
      $error("bus_width_decrease: SIZE_IN must be a multiple of SIZE_OUT with ratio >= 2");
    end
  endgenerate

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SIZE_IN-1:0]   r_shreg;
  logic [c_cnt_w-1:0]   r_beat_cnt;
  logic                 w_last_beat;
  logic                 w_in_xfer;
  logic                 w_out_xfer;

  assign w_last_beat = (r_beat_cnt == c_last);
  assign w_in_xfer   = valid_in && ready_in;
  assign w_out_xfer  = valid_out && ready_out;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_in_xfer) w_state_nxt = SEND;
      SEND: if (w_out_xfer && w_last_beat && !valid_in) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ready_in depends combinationally on ready_out so a new word can be taken
  // on the same edge the final beat leaves (no bubble between words).
  always_comb begin
    ready_in  = 1'b0;
    valid_out = 1'b0;
    if (reset) begin
      case (r_state)
        IDLE: ready_in = 1'b1;
        SEND: begin
          valid_out = 1'b1;
          ready_in  = w_last_beat && ready_out;
        end
        default: ready_in = 1'b0;
      endcase
    end
  end

  assign data_out = r_shreg[SIZE_OUT-1:0];

`ifdef BUS_WIDTH_DECREASE_LAST_EN
  assign last_out = valid_out && w_last_beat;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_shreg    <= '0;
      r_beat_cnt <= '0;
    end else if (w_in_xfer) begin
      r_shreg    <= data_in;
      r_beat_cnt <= '0;
    end else if (w_out_xfer) begin
      r_shreg    <= r_shreg >> SIZE_OUT;
      r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + c_cnt_w'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_width_decrease.sv
// ============================================================================
// tb_bus_width_decrease : directed and scoreboard checks for bus_width_decrease.
//   Revision 1.0
// ============================================================================
`default_nettype none

module tb_bus_width_decrease;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] data_in;
  logic        valid_out;
  logic        ready_out;
  logic [7:0]  data_out;
`ifdef BUS_WIDTH_DECREASE_LAST_EN
  logic        last_out;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bus_width_decrease #(.SIZE_IN(32), .SIZE_OUT(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_in   (data_in),
    .valid_out (valid_out),
    .ready_out (ready_out),
`ifdef BUS_WIDTH_DECREASE_LAST_EN
    .last_out  (last_out),
`endif
    .data_out  (data_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [31:0] w);
    @(negedge clk);
    valid_in  = 1'b1;
    data_in   = w;
    ready_out = 1'b1;
    #1 check("load_rdy", {31'd0, ready_in}, 32'd1);
    @(posedge clk);
  endtask

  // Checks RATIO beats with ready_out high and no further word offered.
  task automatic expect_beats(input logic [31:0] w);
    logic [31:0] tmp;
    tmp = w;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      valid_in = 1'b0;
      #1;
      check("beat_data", {24'd0, data_out}, {24'd0, tmp[7:0]});
      check("beat_valid", {31'd0, valid_out}, 32'd1);
      check("beat_rdy", {31'd0, ready_in}, (i == 3) ? 32'd1 : 32'd0);
`ifdef BUS_WIDTH_DECREASE_LAST_EN
      check("beat_last", {31'd0, last_out}, (i == 3) ? 32'd1 : 32'd0);
`endif
      tmp = tmp >> 8;
      @(posedge clk);
    end
    @(negedge clk);
    #1 check("idle_valid", {31'd0, valid_out}, 32'd0);
  endtask

  initial begin
    logic [31:0] words [20];
    logic [7:0]  stall_exp [7];
    logic        stall_ro  [7];
    logic [31:0] acc;
    logic        a, o;
    logic [7:0]  d;
    int idx, rx, nb, cyc;

    reset = 1'b0; valid_in = 1'b0; data_in = '0; ready_out = 1'b1;

    // Reset held three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 check("rst_hold_rdy", {31'd0, ready_in}, 32'd0);
    reset = 1'b1;
    #1;
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_data", {24'd0, data_out}, 32'd0);
    check("rst_rdy", {31'd0, ready_in}, 32'd1);

    // Single word
    load(32'hDDCCBBAA);
    expect_beats(32'hDDCCBBAA);

    // Back-to-back words, valid_in held high
    @(negedge clk);
    valid_in = 1'b1; data_in = 32'h44332211; ready_out = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 3) data_in = 32'h88776655;
      if (i == 7) valid_in = 1'b0;
      #1;
      check("b2b_data", {24'd0, data_out}, 32'(8'h11 * (i + 1)));
      check("b2b_valid", {31'd0, valid_out}, 32'd1);
      check("b2b_rdy", {31'd0, ready_in}, (i == 3 || i == 7) ? 32'd1 : 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    #1 check("b2b_idle", {31'd0, valid_out}, 32'd0);

    // Stall on beat 02
    stall_ro  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    stall_exp = '{8'h01, 8'h02, 8'h02, 8'h02, 8'h02, 8'h03, 8'h04};
    load(32'h04030201);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      valid_in  = 1'b0;
      ready_out = stall_ro[i];
      #1;
      check("stall_data", {24'd0, data_out}, {24'd0, stall_exp[i]});
      check("stall_valid", {31'd0, valid_out}, 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    #1 check("stall_idle", {31'd0, valid_out}, 32'd0);

    // Reset mid-word
    load(32'hCAFEBABE);
    @(negedge clk);
    valid_in = 1'b0;
    #1 check("mid_beat0", {24'd0, data_out}, 32'h000000BE);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 check("mid_rst_rdy", {31'd0, ready_in}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_valid", {31'd0, valid_out}, 32'd0);
    check("mid_rdy", {31'd0, ready_in}, 32'd1);
    check("mid_data", {24'd0, data_out}, 32'd0);
    load(32'h12345678);
    expect_beats(32'h12345678);

    // Random words, random backpressure, reassembled and compared in order
    foreach (words[i]) words[i] = $urandom;
    idx = 0; rx = 0; nb = 0; cyc = 0; acc = '0;
    while (rx < 20 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      valid_in  = (idx < 20);
      data_in   = (idx < 20) ? words[idx] : 32'd0;
      ready_out = ($urandom_range(0, 3) != 0);
      #1;
      a = valid_in && ready_in;
      o = valid_out && ready_out;
      d = data_out;
      @(posedge clk);
      if (a) idx++;
      if (o) begin
        acc = {d, acc[31:8]};
        nb++;
        if (nb == 4) begin
          check("rand_word", acc, words[rx]);
          rx++;
          nb = 0;
        end
      end
    end
    check("rand_count", 32'(rx), 32'd20);
    @(negedge clk);
    valid_in = 1'b0;
    ready_out = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1 check("rand_idle", {31'd0, valid_out}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bus_width_decrease.md
Name: bus_width_decrease

Overview:
- Serializer that splits each SIZE_IN-bit word into RATIO = SIZE_IN/SIZE_OUT narrow beats, least-significant slice first.
- It is the counterpart of the width-increase packer. It sits downstream of wide datapath logic and feeds narrow consumers such as UART TX and byte FIFOs.
- Both sides use a valid/ready handshake, so the block can absorb backpressure.

Parameters:
- SIZE_IN, 32, width of input words in bits.
- SIZE_OUT, 8, width of output beats in bits. SIZE_IN must be an integer multiple of SIZE_OUT with RATIO >= 2; otherwise elaboration fails via $error.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- valid_in  input  1  input word valid.
- ready_in  output  1  block can accept a word this cycle.
- data_in  input  SIZE_IN  input word.
- valid_out  output  1  output beat valid.
- ready_out  input  1  downstream accepts beat this cycle.
- data_out  output  SIZE_OUT  current beat.

Behaviour:
- Handshakes: an input transfer occurs when valid_in && ready_in at posedge clk. An output transfer occurs when valid_out && ready_out at posedge clk.
- Reset (reset==0 at posedge): state=IDLE, beat_cnt=0, shift register cleared. valid_out=0 and data_out=0 at reset and until the first word is loaded. While reset==0, ready_in is forced to 0.
- State machine, two states:
  - IDLE: ready_in=1, valid_out=0. An input transfer loads data_in into the shift register, sets beat_cnt=0 and moves to SEND.
  - SEND: valid_out=1 and data_out = shreg[SIZE_OUT-1:0]. Each output transfer shifts shreg right by SIZE_OUT and increments beat_cnt.
- Last beat in SEND (beat_cnt==RATIO-1) when it transfers:
  - if valid_in is also high, load the new word, set beat_cnt=0 and stay in SEND (back-to-back, no bubble);
  - otherwise go to IDLE.
- ready_in = (state==IDLE) || (state==SEND && beat_cnt==RATIO-1 && ready_out). This is a combinational path from ready_out to ready_in and is documented as such.
- Latency: a word accepted at edge N presents beat 0 during cycle N+1. With ready_out held high, one word is sustained every RATIO cycles.
- Stall: with ready_out=0, valid_out and data_out hold stable. valid_out never drops once asserted until the beat transfers.
- valid_in while SEND and not on the last transferring beat: ready_in=0 and the word is not accepted; the upstream must hold it.
- beat_cnt width is $clog2(RATIO) and it never exceeds RATIO-1.
- Reset asserted mid-word: the partial word is discarded with no further beats. After release the block is in IDLE with ready_in=1.

Optional Feature:
- Macro BUS_WIDTH_DECREASE_LAST_EN.
- Defined: adds output port last_out (1 bit), equal to valid_out && beat_cnt==RATIO-1; reset value 0.
- Undefined: the port is absent and behaviour is otherwise identical.

Decomposition:
- Shared package fifo_pkg holds the state enum typedef (IDLE, SEND) and a constant function for the ratio/count-width computation, reusable by bus_width_increase.
- No sub-module; a single module of roughly 120-180 lines.

Test Plan:
- Reset with reset=0 for 3 cycles, then release → valid_out=0, data_out=0, ready_in=1 in the first cycle after release.
- Send 0xDDCCBBAA with ready_out held 1 → data_out sequence AA, BB, CC, DD on 4 consecutive cycles. ready_in=1 only with the DD beat. last_out=1 only with DD when the macro is defined.
- Back-to-back words 0x44332211 and 0x88776655 with valid_in held high → 8 contiguous beats 11..88 with no bubble.
- Send 0x04030201 and drop ready_out to 0 for 3 cycles after beat 02 → data_out stays 02 and valid_out stays 1 while stalled; then 03, 04 follow.
- Assert reset=0 after beat 1 of 0xCAFEBABE → no further beats; after release valid_out=0, ready_in=1; next word 0x12345678 yields 78, 56, 34, 12.
- Drive 20 random words with random ready_out → scoreboard reassembly of the beats matches every input word in order with no loss or duplication.
